mac4b_issue_ctrl: RTL and testbench
===================================

Name: mac4b_issue_ctrl

Overview:
- Single-outstanding CV-X-IF issue/commit/result controller for the MAC4B coprocessor datapath.
- Decodes offloaded instructions and accepts MAC4B only.
- Latches operands, waits for commit or kill, starts the variable-latency MAC datapath, and returns its result on the result interface.
- Sits between the CVA6 CV-X-IF port and the MAC4B arithmetic unit.

Parameters:
- X_ID_WIDTH, 3, width of the instruction ID.
- XLEN, 32, operand and result width.
- X_NUM_RS, 2, number of source registers; all are required for MAC4B.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  issue request ready.
- issue_instr_i  in  32  offloaded instruction word.
- issue_id_i  in  X_ID_WIDTH  instruction ID.
- issue_rs_i  in  X_NUM_RS*XLEN  source operands; rs1 in the low slice.
- issue_rs_valid_i  in  X_NUM_RS  per-operand valid.
- issue_accept_o  out  1  instruction accepted; valid during the issue handshake.
- issue_writeback_o  out  1  equals issue_accept_o.
- commit_valid_i  in  1  commit event.
- commit_id_i  in  X_ID_WIDTH  committed ID.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- mac_start_o  out  1  one-cycle start pulse to the datapath.
- mac_rs1_o  out  XLEN  latched rs1.
- mac_rs2_o  out  XLEN  latched rs2.
- mac_done_i  in  1  datapath result valid (single-cycle pulse).
- mac_result_i  in  XLEN  datapath result.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  result ready.
- result_id_o  out  X_ID_WIDTH  ID of the result.
- result_rd_o  out  5  destination register, instr[11:7].
- result_data_o  out  XLEN  result data.
- result_we_o  out  1  write enable; equals result_valid_o.
- busy_o  out  1  state != IDLE.
- done_cnt_o  out  32  count of completed results; wraps at 2^32.

Behaviour:
- Decode: match = (issue_instr_i & 32'hFE00707F) == 32'h04000033.
- States: IDLE, WAIT_COMMIT, EXEC, RESULT. Reset enters IDLE.
- Reset values: all registered outputs 0, done_cnt_o 0.
- issue_ready_o is forced to 0 while rst_ni is low.
- Reset mid-operation abandons the instruction; no result is produced.
- IDLE:
  - issue_ready_o = 1 if !match, or if match and all issue_rs_valid_i bits are set. Otherwise 0 (stall until operands are valid).
  - issue_accept_o = issue_valid_i & match & (&issue_rs_valid_i), combinational.
  - Handshake with match: latch issue_id_i, instr[11:7], rs1, rs2; next state WAIT_COMMIT.
  - Handshake without match: accept = 0, stay in IDLE.
  - commit_valid_i is ignored in IDLE.
- WAIT_COMMIT:
  - issue_ready_o = 0.
  - On commit_valid_i with commit_id_i == latched ID:
    - kill = 1: next state IDLE, no start pulse.
    - kill = 0: next state EXEC, mac_start_o = 1 in the first EXEC cycle only.
  - Commits with a non-matching ID are ignored.
- EXEC:
  - issue_ready_o = 0. mac_rs1_o and mac_rs2_o are held stable.
  - mac_done_i is sampled only from the cycle after the start pulse. Done coincident with start is ignored.
  - On done: capture mac_result_i into result_data_o; next state RESULT.
  - Minimum total latency from commit to result_valid_o is 3 cycles.
- RESULT:
  - result_valid_o = 1; id, rd and data held stable until result_ready_i.
  - On handshake: done_cnt_o increments; next state IDLE.
  - A new issue can be accepted in the following cycle, never in the handshake cycle.
- mac_done_i outside EXEC is ignored.
- result_valid_o is low in every state other than RESULT.

Test Plan:
- Issue instr 0x04B50533 (MAC4B; rd=10), id=2, rs1=0x01020304, rs2=0x01010101, all rs valid -> accept=1, writeback=1. Then commit id=2, kill=0 -> mac_start_o pulses once. Then mac_done_i with 0x0000000A two cycles later -> result_valid_o=1, id=2, rd=10, data=0xA. done_cnt_o=1 after the handshake.
- Issue non-matching 0x00B50533 (ADD) -> issue_ready_o=1, accept=0. State stays IDLE; no start pulse.
- Issue MAC4B with rs_valid=2'b01 for 3 cycles, then 2'b11 -> issue_ready_o=0 for 3 cycles, handshake on the 4th.
- Accepted MAC4B id=5; commit id=4 (ignored), then commit id=5 with kill=1 -> returns to IDLE, no mac_start_o, done_cnt_o unchanged.
- In RESULT with result_ready_i=0 for 4 cycles, toggle mac_result_i -> result_data_o stable. Assert result_ready_i -> IDLE next cycle. Issue in the same cycle as that handshake is not accepted.
- Deassert rst_ni during EXEC -> all outputs 0 and state IDLE immediately. After release, a new MAC4B completes normally.

Source files
------------

// File: rtl/mac4b_issue_ctrl.sv
// mac4b_issue_ctrl
//
// Single-outstanding CV-X-IF issue/commit/result controller for the MAC4B
// coprocessor datapath. Sits between the CVA6 CV-X-IF port and the MAC4B
// arithmetic unit. Decodes offloaded instructions and accepts MAC4B only,
// latches the operands, waits for commit or kill, fires the variable-latency
// datapath and hands its result back on the result interface.
//
// State table
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   IDLE        | ready for a new offload; non-MAC4B instructions are refused
//   WAIT_COMMIT | MAC4B accepted, operands latched, waiting for commit/kill
//   EXEC        | datapath started (mac_start_o in the first cycle), await done
//   RESULT      | result presented, held until result_ready_i
//
// Ports
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   issue_*                      CV-X-IF issue request / response
//   commit_*                     CV-X-IF commit (kill = 1 abandons the instr)
//   mac_start_o, mac_rs1/2_o     datapath start pulse and latched operands
//   mac_done_i, mac_result_i     datapath completion pulse and result
//   result_*                     CV-X-IF result interface
//   busy_o                       controller not in IDLE
//   done_cnt_o                   completed-result counter, wraps at 2^32

module mac4b_issue_ctrl #(
    parameter int X_ID_WIDTH = 3,
    parameter int XLEN       = 32,
    parameter int X_NUM_RS   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [31:0]              issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]    issue_id_i,
    input  logic [X_NUM_RS*XLEN-1:0] issue_rs_i,
    input  logic [X_NUM_RS-1:0]      issue_rs_valid_i,
    output logic                     issue_accept_o,
    output logic                     issue_writeback_o,

    input  logic                     commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]    commit_id_i,
    input  logic                     commit_kill_i,

    output logic                     mac_start_o,
    output logic [XLEN-1:0]          mac_rs1_o,
    output logic [XLEN-1:0]          mac_rs2_o,
    input  logic                     mac_done_i,
    input  logic [XLEN-1:0]          mac_result_i,

    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [X_ID_WIDTH-1:0]    result_id_o,
    output logic [4:0]               result_rd_o,
    output logic [XLEN-1:0]          result_data_o,
    output logic                     result_we_o,

    output logic                     busy_o,
    output logic [31:0]              done_cnt_o
);

    localparam logic [31:0] MAC4B_MASK  = 32'hFE00707F;
    localparam logic [31:0] MAC4B_MATCH = 32'h04000033;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_COMMIT = 2'd1,
        EXEC        = 2'd2,
        RESULT      = 2'd3
    } state_t;

    state_t state;

    logic is_mac4b;
    logic rs_all_valid;
    logic in_idle;
    logic commit_hit;

    assign is_mac4b     = (issue_instr_i & MAC4B_MASK) == MAC4B_MATCH;
    assign rs_all_valid = &issue_rs_valid_i;
    assign in_idle      = (state == IDLE);

    // Non-MAC4B requests are answered immediately (refused); a MAC4B request
    // stalls until every operand is valid. rst_ni gates both so nothing can
    // handshake while the block is held in reset.
    assign issue_ready_o     = rst_ni & in_idle & (~is_mac4b | rs_all_valid);
    assign issue_accept_o    = rst_ni & in_idle & issue_valid_i & is_mac4b & rs_all_valid;
    assign issue_writeback_o = issue_accept_o;

    // result_id_o doubles as the latched instruction ID from issue onwards.
    assign commit_hit = commit_valid_i & (commit_id_i == result_id_o);

    assign result_we_o = result_valid_o;
    assign busy_o      = ~in_idle;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            mac_start_o    <= 1'b0;
            mac_rs1_o      <= '0;
            mac_rs2_o      <= '0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_rd_o    <= '0;
            result_data_o  <= '0;
            done_cnt_o     <= '0;
        end else begin
            mac_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_accept_o) begin
                        result_id_o <= issue_id_i;
                        result_rd_o <= issue_instr_i[11:7];
                        mac_rs1_o   <= issue_rs_i[XLEN-1:0];
                        mac_rs2_o   <= issue_rs_i[2*XLEN-1:XLEN];
                        state       <= WAIT_COMMIT;
                    end
                end
                WAIT_COMMIT: begin
                    if (commit_hit) begin
                        if (commit_kill_i) begin
                            state <= IDLE;
                        end else begin
                            state       <= EXEC;
                            mac_start_o <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // A done seen while start is still high cannot belong to
                    // this operation, so it is only honoured from the next cycle.
                    if (mac_done_i && !mac_start_o) begin
                        result_data_o  <= mac_result_i;
                        result_valid_o <= 1'b1;
                        state          <= RESULT;
                    end
                end
                RESULT: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        done_cnt_o     <= done_cnt_o + 32'd1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac4b_issue_ctrl.sv
// Directed testbench for mac4b_issue_ctrl. Inputs are driven and outputs
// sampled around the falling clock edge; the DUT acts on the rising edge.

module tb_mac4b_issue_ctrl;

    localparam int IDW  = 3;
    localparam int XLEN = 32;
    localparam int NRS  = 2;

    localparam logic [31:0] I_MAC_RD10 = 32'h04B50533;
    localparam logic [31:0] I_MAC_RD15 = 32'h04C587B3;
    localparam logic [31:0] I_ADD      = 32'h00B50533;

    logic              clk;
    logic              rst_n;
    logic              issue_valid;
    logic              issue_ready;
    logic [31:0]       issue_instr;
    logic [IDW-1:0]    issue_id;
    logic [NRS*XLEN-1:0] issue_rs;
    logic [NRS-1:0]    issue_rs_valid;
    logic              issue_accept;
    logic              issue_writeback;
    logic              commit_valid;
    logic [IDW-1:0]    commit_id;
    logic              commit_kill;
    logic              mac_start;
    logic [XLEN-1:0]   mac_rs1;
    logic [XLEN-1:0]   mac_rs2;
    logic              mac_done;
    logic [XLEN-1:0]   mac_result;
    logic              result_valid;
    logic              result_ready;
    logic [IDW-1:0]    result_id;
    logic [4:0]        result_rd;
    logic [XLEN-1:0]   result_data;
    logic              result_we;
    logic              busy;
    logic [31:0]       done_cnt;

    int checks = 0;
    int errors = 0;

    mac4b_issue_ctrl #(.X_ID_WIDTH(IDW), .XLEN(XLEN), .X_NUM_RS(NRS)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_instr_i     (issue_instr),
        .issue_id_i        (issue_id),
        .issue_rs_i        (issue_rs),
        .issue_rs_valid_i  (issue_rs_valid),
        .issue_accept_o    (issue_accept),
        .issue_writeback_o (issue_writeback),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .mac_start_o       (mac_start),
        .mac_rs1_o         (mac_rs1),
        .mac_rs2_o         (mac_rs2),
        .mac_done_i        (mac_done),
        .mac_result_i      (mac_result),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .result_id_o       (result_id),
        .result_rd_o       (result_rd),
        .result_data_o     (result_data),
        .result_we_o       (result_we),
        .busy_o            (busy),
        .done_cnt_o        (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full clock: through the rising edge, back to the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_issue(input logic [31:0] instr, input logic [IDW-1:0] id,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [1:0] rsv);
        issue_valid    = 1'b1;
        issue_instr    = instr;
        issue_id       = id;
        issue_rs       = {rs2, rs1};
        issue_rs_valid = rsv;
    endtask

    task automatic clear_issue();
        issue_valid    = 1'b0;
        issue_rs_valid = 2'b00;
    endtask

    task automatic do_commit(input logic [IDW-1:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        cyc();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_issue(I_MAC_RD10, 3'd1, 32'h1, 32'h2, 2'b11);
        repeat (2) cyc();
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready: got %0h want 0", issue_ready); end
        checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL reset_accept: got %0h want 0", issue_accept); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h want 0", busy); end
        checks++; if (result_valid !== 1'b0 || result_we !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %0h/%0h want 0/0", result_valid, result_we); end
        checks++; if (done_cnt !== 32'd0) begin errors++; $display("FAIL reset_done_cnt: got %0h want 0", done_cnt); end
        checks++; if (mac_start !== 1'b0 || mac_rs1 !== 32'd0 || result_data !== 32'd0) begin errors++; $display("FAIL reset_regs: start %0h rs1 %0h data %0h want all 0", mac_start, mac_rs1, result_data); end
        clear_issue();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_mac_basic();
        drive_issue(I_MAC_RD10, 3'd2, 32'h01020304, 32'h01010101, 2'b11);
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %0h want 1", issue_ready); end
        checks++; if (issue_accept !== 1'b1 || issue_writeback !== 1'b1) begin errors++; $display("FAIL basic_accept: got %0h/%0h want 1/1", issue_accept, issue_writeback); end
        cyc();
        clear_issue();
        #1;
        checks++; if (busy !== 1'b1 || issue_ready !== 1'b0) begin errors++; $display("FAIL basic_wait_state: busy %0h ready %0h want 1/0", busy, issue_ready); end
        checks++; if (mac_rs1 !== 32'h01020304 || mac_rs2 !== 32'h01010101) begin errors++; $display("FAIL basic_operands: got %h %h want 01020304 01010101", mac_rs1, mac_rs2); end
        checks++; if (mac_start !== 1'b0) begin errors++; $display("FAIL basic_no_early_start: got %0h want 0", mac_start); end
        do_commit(3'd2, 1'b0);
        #1;
        checks++; if (mac_start !== 1'b1) begin errors++; $display("FAIL basic_start_pulse: got %0h want 1", mac_start); end
        cyc();
        #1;
        checks++; if (mac_start !== 1'b0) begin errors++; $display("FAIL basic_start_single: got %0h want 0", mac_start); end
        mac_done   = 1'b1;
        mac_result = 32'h0000000A;
        cyc();
        mac_done   = 1'b0;
        mac_result = 32'hFFFF0000;
        #1;
        checks++; if (result_valid !== 1'b1 || result_we !== 1'b1) begin errors++; $display("FAIL basic_result_valid: got %0h/%0h want 1/1", result_valid, result_we); end
        checks++; if (result_id !== 3'd2 || result_rd !== 5'd10 || result_data !== 32'hA) begin errors++; $display("FAIL basic_result_fields: id %0d rd %0d data %h want 2 10 0000000a", result_id, result_rd, result_data); end
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_back_idle: valid %0h busy %0h want 0/0", result_valid, busy); end
        checks++; if (done_cnt !== 32'd1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_nonmatch();
        drive_issue(I_ADD, 3'd3, 32'h5, 32'h6, 2'b00);
        #1;
        checks++; if (issue_ready !== 1'b1 || issue_accept !== 1'b0 || issue_writeback !== 1'b0) begin errors++; $display("FAIL nonmatch_resp: ready %0h accept %0h wb %0h want 1/0/0", issue_ready, issue_accept, issue_writeback); end
        cyc();
        clear_issue();
        #1;
        checks++; if (busy !== 1'b0 || mac_start !== 1'b0) begin errors++; $display("FAIL nonmatch_idle: busy %0h start %0h want 0/0", busy, mac_start); end
        // done and commit pulses in IDLE must have no effect
        mac_done     = 1'b1;
        mac_result   = 32'h77;
        commit_valid = 1'b1;
        commit_id    = 3'd2;
        cyc();
        mac_done     = 1'b0;
        commit_valid = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0 || mac_start !== 1'b0) begin errors++; $display("FAIL idle_ignore: valid %0h busy %0h start %0h want 0/0/0", result_valid, busy, mac_start); end
    endtask

    task automatic test_stall();
        drive_issue(I_MAC_RD10, 3'd3, 32'h11, 32'h22, 2'b01);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (issue_ready !== 1'b0 || issue_accept !== 1'b0) begin errors++; $display("FAIL stall_cycle%0d: ready %0h accept %0h want 0/0", i, issue_ready, issue_accept); end
            cyc();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_still_idle: got %0h want 0", busy); end
        issue_rs_valid = 2'b11;
        #1;
        checks++; if (issue_ready !== 1'b1 || issue_accept !== 1'b1) begin errors++; $display("FAIL stall_release: ready %0h accept %0h want 1/1", issue_ready, issue_accept); end
        cyc();
        clear_issue();
        #1;
        checks++; if (busy !== 1'b1 || mac_rs2 !== 32'h22) begin errors++; $display("FAIL stall_accepted: busy %0h rs2 %h want 1 00000022", busy, mac_rs2); end
        do_commit(3'd3, 1'b1);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_cleanup: busy %0h want 0", busy); end
    endtask

    task automatic test_kill();
        drive_issue(I_MAC_RD10, 3'd5, 32'hA, 32'hB, 2'b11);
        cyc();
        clear_issue();
        // done before commit must not advance the state
        mac_done = 1'b1;
        do_commit(3'd4, 1'b0);
        mac_done = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || mac_start !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL kill_wrong_id: busy %0h start %0h valid %0h want 1/0/0", busy, mac_start, result_valid); end
        do_commit(3'd5, 1'b1);
        #1;
        checks++; if (busy !== 1'b0 || mac_start !== 1'b0) begin errors++; $display("FAIL kill_idle: busy %0h start %0h want 0/0", busy, mac_start); end
        cyc();
        #1;
        checks++; if (mac_start !== 1'b0 || done_cnt !== 32'd1) begin errors++; $display("FAIL kill_after: start %0h cnt %0d want 0 1", mac_start, done_cnt); end
    endtask

    task automatic test_done_timing();
        drive_issue(I_MAC_RD10, 3'd1, 32'h3, 32'h4, 2'b11);
        cyc();
        clear_issue();
        do_commit(3'd1, 1'b0);
        // start cycle: a coincident done is ignored
        mac_done   = 1'b1;
        mac_result = 32'hBADBAD00;
        cyc();
        mac_done = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL done_with_start: valid %0h busy %0h want 0/1", result_valid, busy); end
        mac_done   = 1'b1;
        mac_result = 32'h00000055;
        cyc();
        mac_done = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b1 || result_data !== 32'h55) begin errors++; $display("FAIL done_after_start: valid %0h data %h want 1 00000055", result_valid, result_data); end
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        #1;
        checks++; if (done_cnt !== 32'd2) begin errors++; $display("FAIL done_timing_cnt: got %0d want 2", done_cnt); end
    endtask

    task automatic test_back_to_back();
        drive_issue(I_MAC_RD15, 3'd6, 32'hC, 32'hD, 2'b11);
        cyc();
        clear_issue();
        do_commit(3'd6, 1'b0);
        cyc();
        mac_done   = 1'b1;
        mac_result = 32'h12345678;
        cyc();
        mac_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mac_result = 32'hA5A5A5A5 ^ i;
            #1;
            checks++; if (result_valid !== 1'b1 || result_data !== 32'h12345678 || result_id !== 3'd6 || result_rd !== 5'd15) begin errors++; $display("FAIL hold_cycle%0d: valid %0h data %h id %0d rd %0d want 1 12345678 6 15", i, result_valid, result_data, result_id, result_rd); end
            cyc();
        end
        result_ready = 1'b1;
        drive_issue(I_MAC_RD10, 3'd7, 32'hE, 32'hF, 2'b11);
        #1;
        checks++; if (issue_ready !== 1'b0 || issue_accept !== 1'b0) begin errors++; $display("FAIL handshake_cycle_issue: ready %0h accept %0h want 0/0", issue_ready, issue_accept); end
        cyc();
        result_ready = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== 32'd3) begin errors++; $display("FAIL handshake_idle: valid %0h busy %0h cnt %0d want 0 0 3", result_valid, busy, done_cnt); end
        checks++; if (issue_ready !== 1'b1 || issue_accept !== 1'b1) begin errors++; $display("FAIL next_cycle_issue: ready %0h accept %0h want 1/1", issue_ready, issue_accept); end
        cyc();
        clear_issue();
        #1;
        checks++; if (busy !== 1'b1 || result_id !== 3'd7) begin errors++; $display("FAIL next_cycle_latched: busy %0h id %0d want 1 7", busy, result_id); end
        do_commit(3'd7, 1'b1);
    endtask

    task automatic test_reset_mid_exec();
        drive_issue(I_MAC_RD10, 3'd1, 32'h99, 32'h88, 2'b11);
        cyc();
        clear_issue();
        do_commit(3'd1, 1'b0);
        cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_exec: busy %0h want 1", busy); end
        rst_n = 1'b0;
        drive_issue(I_MAC_RD10, 3'd2, 32'h1, 32'h1, 2'b11);
        #1;
        checks++; if (busy !== 1'b0 || issue_ready !== 1'b0 || issue_accept !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: busy %0h ready %0h accept %0h want 0/0/0", busy, issue_ready, issue_accept); end
        checks++; if (mac_rs1 !== 32'd0 || done_cnt !== 32'd0 || result_valid !== 1'b0 || mac_start !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: rs1 %h cnt %0d valid %0h start %0h want 0", mac_rs1, done_cnt, result_valid, mac_start); end
        mac_done = 1'b1;
        cyc();
        mac_done = 1'b0;
        clear_issue();
        rst_n = 1'b1;
        cyc();
        checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_result: valid %0h busy %0h want 0/0", result_valid, busy); end
        drive_issue(I_MAC_RD15, 3'd4, 32'h10, 32'h20, 2'b11);
        cyc();
        clear_issue();
        do_commit(3'd4, 1'b0);
        cyc();
        mac_done   = 1'b1;
        mac_result = 32'hDEADBEEF;
        cyc();
        mac_done = 1'b0;
        #1;
        checks++; if (result_valid !== 1'b1 || result_data !== 32'hDEADBEEF || result_id !== 3'd4 || result_rd !== 5'd15) begin errors++; $display("FAIL rst_recover_result: valid %0h data %h id %0d rd %0d want 1 deadbeef 4 15", result_valid, result_data, result_id, result_rd); end
        result_ready = 1'b1;
        cyc();
        result_ready = 1'b0;
        #1;
        checks++; if (done_cnt !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL rst_recover_cnt: cnt %0d busy %0h want 1 0", done_cnt, busy); end
    endtask

    initial begin
        rst_n          = 1'b0;
        issue_valid    = 1'b0;
        issue_instr    = 32'd0;
        issue_id       = '0;
        issue_rs       = '0;
        issue_rs_valid = '0;
        commit_valid   = 1'b0;
        commit_id      = '0;
        commit_kill    = 1'b0;
        mac_done       = 1'b0;
        mac_result     = '0;
        result_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_mac_basic();
        test_nonmatch();
        test_stall();
        test_kill();
        test_done_timing();
        test_back_to_back();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
